pipeline_controller: RTL

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pipeline_controller.sv
// Pipeline hazard controller: two-state memory-wait FSM with Mealy stall/flush
// controls, saturating stall/flush counters and a sticky memory-timeout flag.
module pipeline_controller #(
  parameter int unsigned TIMEOUT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rd_e,
  input  logic        load_e,
  input  logic        branch_taken_e,
  input  logic        dmem_req_m,
  input  logic        dmem_ready_m,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_write,
  output logic        id_ex_flush,
  output logic        ex_mem_write,
  output logic        mem_wb_bubble,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        mem_timeout
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;

  logic hazard_match;
  logic mem_wait;
  logic branch_flush;
  logic load_use;

  // Event decode in priority order: memory wait masks branch, branch masks load-use.
  always_comb begin
    hazard_match = (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    mem_wait     = (state_q == MEM_WAIT) ? !dmem_ready_m
                                         : (dmem_req_m && !dmem_ready_m);
    branch_flush = !mem_wait && branch_taken_e;
    load_use     = !mem_wait && !branch_taken_e && load_e && hazard_match;
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    if (mem_wait) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (branch_flush) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d       = mem_wait ? MEM_WAIT : RUN;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;

    // Counter saturates so a stuck memory cannot wrap it back below the limit.
    if (state_q == RUN && mem_wait) begin
      wait_cnt_d = '0;
    end else if (state_q == MEM_WAIT && mem_wait && wait_cnt_q != '1) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end

    if (state_q == MEM_WAIT && mem_wait && 32'(wait_cnt_d) >= TIMEOUT_LIMIT) begin
      mem_timeout_d = 1'b1;
    end

    if ((mem_wait || load_use) && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (branch_flush && flush_cnt_q != '1) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign mem_timeout = mem_timeout_q;

endmodule
